// File: rtl/blit_pkg.sv
// Shared types for the blitter pattern-fetch sequencer: FSM state encoding and
// the default pixel-counter width.
package blit_pkg;

    localparam int PAT_CNT_W_DEFAULT = 10;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        WRITE,
        STEP,
        FINISH
    } pat_state_t;

endpackage

// File: rtl/pix_down_counter.sv
// Loadable down-counter holding the pixels remaining in a blitter run.
// Saturates at zero so the remaining-pixel status can never wrap.
module pix_down_counter
    import blit_pkg::*;
#(
    parameter int CNT_W = PAT_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             is_zero,
    output logic             is_one
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (dec && !is_zero) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count   = count_reg;
    assign is_zero = (count_reg == '0);
    assign is_one  = (count_reg == CNT_W'(1));

endmodule

// File: rtl/pat_fetch_ctrl.sv
// Pattern data register sequencer: fetches source bytes, pulses the pattern
// latch load, and hands each byte to the destination-write stage.
// Optional SUSPEND input (hold between pixels) enabled by PATFETCH_SUSPEND_EN.
module pat_fetch_ctrl
    import blit_pkg::*;
#(
    parameter int CNT_W = PAT_CNT_W_DEFAULT
) (
    input  logic             MasterClock,
    input  logic             RESET,
    input  logic             START,
    input  logic [CNT_W-1:0] INNER_CNT,
    input  logic             SRCEN,
    output logic             MEM_REQ,
    input  logic             MEM_ACK,
    output logic             LDPATL,
    output logic             WR_REQ,
    input  logic             WR_ACK,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] PIX_LEFT
`ifdef PATFETCH_SUSPEND_EN
    ,
    input  logic             SUSPEND
`endif
);

    pat_state_t state_reg;
    pat_state_t state_next;
    logic       mode_reg;
    logic       mode_next;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_is_zero;
    logic       cnt_is_one;
    logic       hold_step;

    logic mem_req_reg;
    logic ldpatl_reg;
    logic wr_req_reg;
    logic busy_reg;
    logic done_reg;

`ifdef PATFETCH_SUSPEND_EN
    assign hold_step = SUSPEND;
`else
    assign hold_step = 1'b0;
`endif

    pix_down_counter #(
        .CNT_W(CNT_W)
    ) u_pix_cnt (
        .clk     (MasterClock),
        .rst     (RESET),
        .load    (cnt_load),
        .load_val(INNER_CNT),
        .dec     (cnt_dec),
        .count   (PIX_LEFT),
        .is_zero (cnt_is_zero),
        .is_one  (cnt_is_one)
    );

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (START) begin
                    cnt_load   = 1'b1;
                    mode_next  = SRCEN;
                    state_next = (INNER_CNT == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                if (MEM_ACK) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = WRITE;
            end
            WRITE: begin
                if (WR_ACK) begin
                    state_next = STEP;
                end
            end
            STEP: begin
                // The decision looks at the pre-decrement count: one left means
                // this step consumes the last pixel.
                if (!hold_step) begin
                    cnt_dec = 1'b1;
                    if (cnt_is_one || cnt_is_zero) begin
                        state_next = FINISH;
                    end else if (mode_reg) begin
                        state_next = FETCH;
                    end else begin
                        state_next = WRITE;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they are glitch-free flops.
    always_ff @(posedge MasterClock or posedge RESET) begin
        if (RESET) begin
            state_reg   <= IDLE;
            mode_reg    <= 1'b0;
            mem_req_reg <= 1'b0;
            ldpatl_reg  <= 1'b0;
            wr_req_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mode_reg    <= mode_next;
            mem_req_reg <= (state_next == FETCH);
            ldpatl_reg  <= (state_next == LOAD);
            wr_req_reg  <= (state_next == WRITE);
            busy_reg    <= (state_next != IDLE);
            done_reg    <= (state_next == FINISH);
        end
    end

    assign MEM_REQ = mem_req_reg;
    assign LDPATL  = ldpatl_reg;
    assign WR_REQ  = wr_req_reg;
    assign BUSY    = busy_reg;
    assign DONE    = done_reg;

endmodule

// File: tb/tb_pat_fetch_ctrl.sv
// Self-checking bench for pat_fetch_ctrl: directed and randomized runs against
// a cycle-budget and transaction-count model of the run.
module tb_pat_fetch_ctrl;

    localparam int CNT_W = 10;

    logic             MasterClock = 1'b0;
    logic             RESET;
    logic             START;
    logic [CNT_W-1:0] INNER_CNT;
    logic             SRCEN;
    logic             MEM_REQ;
    logic             MEM_ACK;
    logic             LDPATL;
    logic             WR_REQ;
    logic             WR_ACK;
    logic             BUSY;
    logic             DONE;
    logic [CNT_W-1:0] PIX_LEFT;
`ifdef PATFETCH_SUSPEND_EN
    logic             SUSPEND;
`endif

    int checks = 0;
    int errors = 0;

    pat_fetch_ctrl #(.CNT_W(CNT_W)) dut (
        .MasterClock(MasterClock),
        .RESET      (RESET),
        .START      (START),
        .INNER_CNT  (INNER_CNT),
        .SRCEN      (SRCEN),
        .MEM_REQ    (MEM_REQ),
        .MEM_ACK    (MEM_ACK),
        .LDPATL     (LDPATL),
        .WR_REQ     (WR_REQ),
        .WR_ACK     (WR_ACK),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .PIX_LEFT   (PIX_LEFT)
`ifdef PATFETCH_SUSPEND_EN
        ,
        .SUSPEND    (SUSPEND)
`endif
    );

    always #5 MasterClock = ~MasterClock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"}, 32'(MEM_REQ), 0);
        chk({tag, "_ldpatl"}, 32'(LDPATL), 0);
        chk({tag, "_wr_req"}, 32'(WR_REQ), 0);
        chk({tag, "_busy"}, 32'(BUSY), 0);
        chk({tag, "_done"}, 32'(DONE), 0);
        chk({tag, "_pix_left"}, 32'(PIX_LEFT), 0);
    endtask

    // One blitter run. Expected DONE time, transaction counts and the PIX_LEFT
    // trajectory follow from the per-pixel phase lengths the bench chose.
    task automatic run(input int n, input bit mode, input int md, input int wd,
                       input bit rnd, input bit strays, input int abort_wr,
                       input int susp_step, input string tag);
        int  mdel[$];
        int  wdel[$];
        int  exp_done, done_t, done_cnt;
        int  mem_hs, wr_hs, ld_cnt, wr_entries, wait_m, wait_w, exp_left, susp_left;
        int  a, b;
        bit  prev_mem_hs, prev_wr_hs, prev_wr_req, cur_mem_hs, cur_wr_hs;
        bit  step_now, aborted, susp;
        exp_done = 1;
        for (int i = 0; i < n; i++) begin
            a = rnd ? int'($urandom_range(0, md)) : md;
            b = rnd ? int'($urandom_range(0, wd)) : wd;
            mdel.push_back(a);
            wdel.push_back(b);
            if (mode || i == 0) exp_done += a + 2;
            exp_done += b + 2;
        end
        if (susp_step > 0) exp_done += 5;
        done_t = 0; done_cnt = 0; mem_hs = 0; wr_hs = 0; ld_cnt = 0; wr_entries = 0;
        wait_m = 0; wait_w = 0; exp_left = n; susp_left = 0;
        prev_mem_hs = 0; prev_wr_hs = 0; prev_wr_req = 0; step_now = 0; aborted = 0;

        @(negedge MasterClock);
        START = 1'b1; INNER_CNT = CNT_W'(n); SRCEN = mode; MEM_ACK = 1'b0; WR_ACK = 1'b0;

        for (int t = 1; t <= 20000; t++) begin
            @(negedge MasterClock);
            START = 1'b0;
            if (prev_wr_hs) step_now = 1;
            chk({tag, "_excl"}, 32'(MEM_REQ & WR_REQ), 0);
            chk({tag, "_ldpatl"}, 32'(LDPATL), 32'(prev_mem_hs));
            chk({tag, "_pix_left"}, 32'(PIX_LEFT), 32'(exp_left));
            chk({tag, "_busy"}, 32'(BUSY), 1);
            ld_cnt += int'(LDPATL);
            if (DONE) begin
                done_t = t;
                done_cnt++;
                break;
            end
            if (WR_REQ && !prev_wr_req) wr_entries++;
            prev_wr_req = WR_REQ;
            if (abort_wr > 0 && wr_entries == abort_wr) begin
                #2 RESET = 1'b1;
                #1 chk_all_zero({tag, "_async"});
                aborted = 1;
                break;
            end
            cur_mem_hs = 0;
            cur_wr_hs  = 0;
            if (MEM_REQ) begin
                if (wait_m >= ((mem_hs < n) ? mdel[mem_hs] : 0)) begin
                    MEM_ACK = 1'b1; wait_m = 0; mem_hs++; cur_mem_hs = 1;
                end else begin
                    MEM_ACK = 1'b0; wait_m++;
                end
            end else begin
                MEM_ACK = strays ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (WR_REQ) begin
                if (wait_w >= ((wr_hs < n) ? wdel[wr_hs] : 0)) begin
                    WR_ACK = 1'b1; wait_w = 0; wr_hs++; cur_wr_hs = 1;
                end else begin
                    WR_ACK = 1'b0; wait_w++;
                end
            end else begin
                WR_ACK = strays ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (strays) begin
                START     = ($urandom_range(0, 3) == 0);
                INNER_CNT = CNT_W'($urandom);
                SRCEN     = 1'($urandom);
            end
            if (prev_wr_hs && susp_step > 0 && wr_hs == susp_step) susp_left = 5;
            susp = (susp_left > 0);
            if (susp) susp_left--;
`ifdef PATFETCH_SUSPEND_EN
            SUSPEND = susp;
`endif
            if (step_now && !susp) begin
                exp_left--;
                step_now = 0;
            end
            prev_mem_hs = cur_mem_hs;
            prev_wr_hs  = cur_wr_hs;
        end

        START = 1'b0; MEM_ACK = 1'b0; WR_ACK = 1'b0;
`ifdef PATFETCH_SUSPEND_EN
        SUSPEND = 1'b0;
`endif
        if (aborted) begin
            @(negedge MasterClock);
            RESET = 1'b0;
            @(negedge MasterClock);
            chk({tag, "_no_done"}, 32'(DONE), 0);
            chk({tag, "_idle_busy"}, 32'(BUSY), 0);
            $display("run %s n=%0d mode=%0d aborted at write %0d", tag, n, mode, abort_wr);
        end else begin
            chk({tag, "_done_cnt"}, 32'(done_cnt), 1);
            chk({tag, "_done_time"}, 32'(done_t), 32'(exp_done));
            chk({tag, "_mem_cnt"}, 32'(mem_hs), 32'(mode ? n : (n > 0 ? 1 : 0)));
            chk({tag, "_ld_cnt"}, 32'(ld_cnt), 32'(mode ? n : (n > 0 ? 1 : 0)));
            chk({tag, "_wr_cnt"}, 32'(wr_hs), 32'(n));
            @(negedge MasterClock);
            chk_all_zero({tag, "_after"});
            $display("run %s n=%0d mode=%0d done_at=%0d expected=%0d fetches=%0d writes=%0d",
                     tag, n, mode, done_t, exp_done, mem_hs, wr_hs);
        end
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; INNER_CNT = '0; SRCEN = 1'b0;
        MEM_ACK = 1'b0; WR_ACK = 1'b0;
`ifdef PATFETCH_SUSPEND_EN
        SUSPEND = 1'b0;
`endif
        #1 chk_all_zero("reset");
        @(negedge MasterClock);
        @(negedge MasterClock);
        RESET = 1'b0;

        run(5, 1, 0, 0, 0, 0, 3, 0, "rst_mid");
        run(5, 1, 0, 0, 0, 0, 0, 0, "after_rst");
        run(3, 1, 0, 0, 0, 0, 0, 0, "per_pixel");
        run(4, 0, 0, 0, 0, 0, 0, 0, "fetch_once");
        run(3, 1, 3, 2, 0, 0, 0, 0, "wait_states");
        run(3, 0, 3, 2, 0, 0, 0, 0, "wait_once");
        run(0, 1, 0, 0, 0, 0, 0, 0, "zero_cnt");
        run(0, 0, 0, 0, 0, 1, 0, 0, "zero_cnt_stray");

        // Stray acknowledges and no START while idle must leave everything quiet.
        for (int i = 0; i < 3; i++) begin
            @(negedge MasterClock);
            MEM_ACK = 1'b1; WR_ACK = 1'b1;
            @(negedge MasterClock);
            chk_all_zero("idle_stray");
            $display("idle stray ack cycle %0d", i);
        end
        MEM_ACK = 1'b0; WR_ACK = 1'b0;

        run(6, 1, 2, 2, 1, 1, 0, 0, "busy_start");
        for (int r = 0; r < 24; r++) begin
            run(int'($urandom_range(1, 12)), 1'($urandom), 3, 3, 1, 1, 0, 0, "random");
        end
        run(1, 1, 0, 0, 0, 0, 0, 0, "single");
        run(1023, 0, 0, 0, 0, 0, 0, 0, "max_once");
`ifdef PATFETCH_SUSPEND_EN
        run(3, 1, 0, 0, 0, 0, 0, 2, "suspend");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
